// File: rtl/int_ctrl_pkg.sv
// Shared types and constants for the prioritised interrupt controller.
package int_ctrl_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StReq
  } state_e;

  localparam logic [9:0]  DefVecBase   = 10'h3C0;
  localparam int unsigned DefVecStride = 4;

  // Id width that stays at least one bit for a single-source build.
  function automatic int unsigned id_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/int_ctrl_prio_enc.sv
// Priority encoder: reports whether any request bit is set and the lowest set index.
module prio_enc #(
  parameter int unsigned N   = 4,
  parameter int unsigned IdW = 2
) (
  input  logic [N-1:0]   req_i,
  output logic           valid_o,
  output logic [IdW-1:0] idx_o
);

  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    // Walk downwards so the lowest set index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = IdW'(i);
      end
    end
  end

endmodule

// File: rtl/int_ctrl_prio.sv
// Prioritised interrupt controller with edge capture, mask, vectoring and in-service tracking.
// Define INT_CTRL_NESTING_EN to allow strict-priority preemption of in-service sources.
module int_ctrl_prio
  import int_ctrl_pkg::*;
#(
  parameter int unsigned       N_SRC      = 4,
  parameter int unsigned       PC_W       = 10,
  parameter logic [PC_W-1:0]   VEC_BASE   = PC_W'(DefVecBase),
  parameter int unsigned       VEC_STRIDE = DefVecStride,
  localparam int unsigned      IdW        = id_w(N_SRC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_in,
  input  logic             int_ack,
  input  logic             fin_int,
  output logic             int_req,
  output logic [PC_W-1:0]  vector,
  output logic [IdW-1:0]   active_id,
  output logic [N_SRC-1:0] in_service,
  output logic [N_SRC-1:0] pending
);

  state_e             state_q, state_d;
  logic [N_SRC-1:0]   prev_q;
  logic [N_SRC-1:0]   pending_q, pending_d;
  logic [N_SRC-1:0]   mask_q, mask_d;
  logic [N_SRC-1:0]   in_service_q, in_service_d;
  logic               int_req_q, int_req_d;
  logic [PC_W-1:0]    vector_q, vector_d;
  logic [IdW-1:0]     active_id_q, active_id_d;

  logic [N_SRC-1:0]   irq_edge;
  logic [N_SRC-1:0]   allowed;
  logic [N_SRC-1:0]   eligible;
  logic               win_valid;
  logic [IdW-1:0]     win_id;
  logic               fin_valid;
  logic [IdW-1:0]     fin_id;
  logic               ack_fire;
  logic [N_SRC-1:0]   ack_oh;
  logic [N_SRC-1:0]   fin_oh;

  assign irq_edge = irq_src & ~prev_q;

`ifdef INT_CTRL_NESTING_EN
  // Only sources strictly above (lower index than) every in-service source may preempt.
  always_comb begin
    logic seen;
    seen    = 1'b0;
    allowed = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      seen       = seen | in_service_q[i];
      allowed[i] = ~seen;
    end
  end
`else
  assign allowed = {N_SRC{in_service_q == '0}};
`endif

  assign eligible = pending_q & mask_q & ~in_service_q & allowed;

  prio_enc #(
    .N   (N_SRC),
    .IdW (IdW)
  ) u_win_enc (
    .req_i   (eligible),
    .valid_o (win_valid),
    .idx_o   (win_id)
  );

  prio_enc #(
    .N   (N_SRC),
    .IdW (IdW)
  ) u_fin_enc (
    .req_i   (in_service_q),
    .valid_o (fin_valid),
    .idx_o   (fin_id)
  );

  assign ack_fire = (state_q == StReq) && int_ack;
  assign ack_oh   = ack_fire ? (N_SRC'(1) << active_id_q) : '0;
  assign fin_oh   = (fin_int && fin_valid) ? (N_SRC'(1) << fin_id) : '0;

  always_comb begin
    state_d      = state_q;
    int_req_d    = int_req_q;
    vector_d     = vector_q;
    active_id_d  = active_id_q;
    mask_d       = mask_we ? mask_in : mask_q;
    // A fresh edge in the ack cycle re-arms the source being acknowledged.
    pending_d    = (pending_q & ~ack_oh) | irq_edge;
    in_service_d = (in_service_q & ~fin_oh) | ack_oh;

    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          state_d     = StReq;
          int_req_d   = 1'b1;
          active_id_d = win_id;
          vector_d    = VEC_BASE + PC_W'(32'(win_id) * VEC_STRIDE);
        end
      end
      StReq: begin
        if (int_ack) begin
          state_d   = StIdle;
          int_req_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      prev_q       <= '0;
      pending_q    <= '0;
      mask_q       <= '0;
      in_service_q <= '0;
      int_req_q    <= 1'b0;
      vector_q     <= '0;
      active_id_q  <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= irq_src;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      in_service_q <= in_service_d;
      int_req_q    <= int_req_d;
      vector_q     <= vector_d;
      active_id_q  <= active_id_d;
    end
  end

  assign int_req    = int_req_q;
  assign vector     = vector_q;
  assign active_id  = active_id_q;
  assign in_service = in_service_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_int_ctrl_prio.sv
// Directed bench for int_ctrl_prio; follows INT_CTRL_NESTING_EN to pick expectations.
module tb_int_ctrl_prio;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq_src;
  logic       mask_we;
  logic [3:0] mask_in;
  logic       int_ack;
  logic       fin_int;
  logic       int_req;
  logic [9:0] vector;
  logic [1:0] active_id;
  logic [3:0] in_service;
  logic [3:0] pending;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  int_ctrl_prio dut (
    .clk        (clk),
    .reset      (reset),
    .irq_src    (irq_src),
    .mask_we    (mask_we),
    .mask_in    (mask_in),
    .int_ack    (int_ack),
    .fin_int    (fin_int),
    .int_req    (int_req),
    .vector     (vector),
    .active_id  (active_id),
    .in_service (in_service),
    .pending    (pending)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic fin();
    fin_int = 1'b1;
    tick();
    fin_int = 1'b0;
  endtask

  task automatic pulse_src(input logic [3:0] v);
    irq_src = v;
    tick();
    irq_src = 4'b0000;
  endtask

  task automatic set_mask(input logic [3:0] m);
    mask_we = 1'b1;
    mask_in = m;
    tick();
    mask_we = 1'b0;
  endtask

  task automatic chk_req(input string tag, input logic [1:0] id, input logic [9:0] vec);
    chk({tag, ".req"}, 32'(int_req), 32'd1);
    chk({tag, ".id"}, 32'(active_id), 32'(id));
    chk({tag, ".vec"}, 32'(vector), 32'(vec));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".req"}, 32'(int_req), 32'd0);
    chk({tag, ".vec"}, 32'(vector), 32'd0);
    chk({tag, ".id"}, 32'(active_id), 32'd0);
    chk({tag, ".insvc"}, 32'(in_service), 32'd0);
    chk({tag, ".pend"}, 32'(pending), 32'd0);
  endtask

  initial begin
    reset   = 1'b1;
    irq_src = '0;
    mask_we = 1'b0;
    mask_in = '0;
    int_ack = 1'b0;
    fin_int = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk_zero("rst");

    // 1: single source, latency and ack
    set_mask(4'hF);
    pulse_src(4'b0100);
    chk("t1.pend", 32'(pending), 32'b0100);
    chk("t1.req0", 32'(int_req), 32'd0);
    tick();
    chk_req("t1", 2'd2, 10'h3C8);
    ack();
    chk("t1.insvc", 32'(in_service), 32'b0100);
    chk("t1.pend2", 32'(pending), 32'd0);
    chk("t1.reqoff", 32'(int_req), 32'd0);
    fin();
    chk("t1.fin", 32'(in_service), 32'd0);
    // ack while idle must not touch anything
    ack();
    chk("t1.idleack.insvc", 32'(in_service), 32'd0);
    chk("t1.idleack.req", 32'(int_req), 32'd0);

    // 2: simultaneous edges, lower index first
    pulse_src(4'b1010);
    chk("t2.pend", 32'(pending), 32'b1010);
    tick();
    chk_req("t2a", 2'd1, 10'h3C4);
    ack();
    chk("t2.insvc", 32'(in_service), 32'b0010);
    chk("t2.pend2", 32'(pending), 32'b1000);
    tick();
    chk("t2.blocked", 32'(int_req), 32'd0);
    fin();
    chk("t2.fin", 32'(in_service), 32'd0);
    tick();
    chk_req("t2b", 2'd3, 10'h3CC);
    ack();
    fin();

    // 3: masked source held pending until the mask opens
    set_mask(4'b1110);
    pulse_src(4'b0001);
    tick();
    tick();
    chk("t3.masked", 32'(int_req), 32'd0);
    chk("t3.pend", 32'(pending), 32'b0001);
    set_mask(4'hF);
    chk("t3.wait", 32'(int_req), 32'd0);
    tick();
    chk_req("t3", 2'd0, 10'h3C0);
    ack();
    fin();

    // 4/5: high-priority edge while servicing id2
    pulse_src(4'b0100);
    tick();
    ack();
    chk("t45.insvc", 32'(in_service), 32'b0100);
    pulse_src(4'b0001);
    tick();
`ifdef INT_CTRL_NESTING_EN
    chk_req("t4", 2'd0, 10'h3C0);
    ack();
    chk("t4.insvc", 32'(in_service), 32'b0101);
    pulse_src(4'b1000);
    tick();
    tick();
    chk("t4.noreq", 32'(int_req), 32'd0);
    fin();
    chk("t4.fin", 32'(in_service), 32'b0100);
    tick();
    chk("t4.noreq2", 32'(int_req), 32'd0);
    fin();
    tick();
    chk_req("t4b", 2'd3, 10'h3CC);
    ack();
    fin();
`else
    chk("t5.noreq", 32'(int_req), 32'd0);
    tick();
    chk("t5.noreq2", 32'(int_req), 32'd0);
    fin();
    chk("t5.fin", 32'(in_service), 32'd0);
    tick();
    chk_req("t5", 2'd0, 10'h3C0);
    ack();
    fin();
`endif
    // edge on src2 during its own ack keeps it pending
    pulse_src(4'b0100);
    tick();
    chk_req("t5b", 2'd2, 10'h3C8);
    irq_src = 4'b0100;
    ack();
    irq_src = 4'b0000;
    chk("t5b.pend", 32'(pending), 32'b0100);
    chk("t5b.insvc", 32'(in_service), 32'b0100);
    fin();
    tick();
    chk_req("t5c", 2'd2, 10'h3C8);
    ack();
    fin();

    // 6: reset mid-service; held source re-requests afterwards
    pulse_src(4'b0100);
    tick();
    ack();
    irq_src = 4'b0010;
    tick();
    tick();
`ifdef INT_CTRL_NESTING_EN
    chk_req("t6.pre", 2'd1, 10'h3C4);
`else
    chk("t6.pre", 32'(int_req), 32'd0);
`endif
    chk("t6.pre.insvc", 32'(in_service), 32'b0100);
    reset = 1'b1;
    tick();
    chk_zero("t6.rst");
    reset = 1'b0;
    set_mask(4'hF);
    chk("t6.pend", 32'(pending), 32'b0010);
    tick();
    chk_req("t6", 2'd1, 10'h3C4);
    irq_src = 4'b0000;
    ack();
    fin();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
